// File: rtl/fix_trailer_check.sv
// fix_trailer_check: finds the "<SOH>10=ddd<SOH>" trailer in the byte stream,
// converts the three ASCII digits to binary and compares the result with the
// checksum from the upstream checksum stage. It reports one result per message.
//
// Optional feature macro: FIX_TRAILER_STATS_EN
//   When defined, good_cnt_o and bad_cnt_o count the reported messages.
//   Each counter saturates at 16'hFFFF.
//   When not defined, both counters are tied to zero.
//
// Latency note: if a checksum is already latched (or its pulse arrives) when
// the terminating SOH is accepted, the block goes straight to REPORT. This
// skips WAIT_CS, so done_o follows the SOH by exactly one cycle.
module fix_trailer_check #(
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [7:0] SOH_CHAR    = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic [7:0]  checksum_i,
  input  logic        checksum_valid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        match_o,
  output logic        fmt_err_o,
  output logic        timeout_o,
  output logic [7:0]  rx_cs_o,
  output logic [15:0] good_cnt_o,
  output logic [15:0] bad_cnt_o
);

  typedef enum logic [2:0] {
    ST_HUNT, ST_T1, ST_T0, ST_EQ, ST_DIG, ST_TERM, ST_WAIT_CS, ST_REPORT
  } state_t;

  // Last timer value before the timeout fires (only used when TIMEOUT_CYC != 0)
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_r, state_nxt;
  logic [9:0]  acc_r, acc_nxt;
  logic [1:0]  dcnt_r, dcnt_nxt;
  logic [15:0] timer_r, timer_nxt;
  logic [7:0]  cs_val_r;
  logic        cs_have_r, cs_have_nxt;
  logic        busy_r, done_r, match_r, fmt_err_r, timeout_r;
  logic [7:0]  rx_cs_r;

  logic        accept_s, is_digit_s, is_soh_s, cs_pulse_s, cs_avail_s;
  logic        fmt_s, to_s, fmt_err_s;
  logic [7:0]  cs_val_s;

  assign accept_s   = valid_i && !busy_r;
  assign is_digit_s = (data_i >= 8'h30) && (data_i <= 8'h39);
  assign is_soh_s   = (data_i == SOH_CHAR);
  assign cs_pulse_s = checksum_valid_i && (state_r != ST_HUNT);
  assign cs_val_s   = cs_pulse_s ? checksum_i : cs_val_r;
  assign cs_avail_s = cs_have_r || cs_pulse_s;
  assign fmt_err_s  = fmt_s || (acc_nxt > 10'd255);

  // Next-state, digit accumulation and per-message flags
  always_comb begin
    state_nxt = state_r;
    acc_nxt   = acc_r;
    dcnt_nxt  = dcnt_r;
    timer_nxt = timer_r;
    fmt_s     = 1'b0;
    to_s      = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (accept_s && is_soh_s) state_nxt = ST_T1;
        else                      state_nxt = ST_HUNT;
      end
      ST_T1, ST_T0, ST_EQ: begin
        if (accept_s) begin
          if      (state_r == ST_T1 && data_i == 8'h31) state_nxt = ST_T0;
          else if (state_r == ST_T0 && data_i == 8'h30) state_nxt = ST_EQ;
          else if (state_r == ST_EQ && data_i == 8'h3D) begin
            state_nxt = ST_DIG;
            acc_nxt   = 10'd0;
            dcnt_nxt  = 2'd0;
          end
          else if (is_soh_s) state_nxt = ST_T1;
          else               state_nxt = ST_HUNT;
        end else begin
          state_nxt = state_r;
        end
      end
      ST_DIG: begin
        if (accept_s) begin
          if (is_digit_s) begin
            acc_nxt = (acc_r * 10'd10) + {6'd0, data_i[3:0]};
            if (dcnt_r == 2'd2) state_nxt = ST_TERM;
            else                dcnt_nxt  = dcnt_r + 2'd1;
          end else begin
            fmt_s     = 1'b1;
            state_nxt = ST_REPORT;
          end
        end else begin
          state_nxt = ST_DIG;
        end
      end
      ST_TERM: begin
        if (accept_s) begin
          if (is_soh_s) begin
            timer_nxt = 16'd0;
            if (cs_avail_s) state_nxt = ST_REPORT;
            else            state_nxt = ST_WAIT_CS;
          end else begin
            fmt_s     = 1'b1;
            state_nxt = ST_REPORT;
          end
        end else begin
          state_nxt = ST_TERM;
        end
      end
      ST_WAIT_CS: begin
        if (cs_avail_s) begin
          state_nxt = ST_REPORT;
        end else if ((TIMEOUT_CYC != 0) && (timer_r == TMO_LAST)) begin
          to_s      = 1'b1;
          state_nxt = ST_REPORT;
        end else begin
          timer_nxt = timer_r + 16'd1;
        end
      end
      ST_REPORT: state_nxt = ST_HUNT;
      default:   state_nxt = ST_HUNT;
    endcase
  end

  // Checksum-present flag: dropped when a report starts or the hunt restarts
  always_comb begin
    if ((state_nxt == ST_HUNT) || (state_nxt == ST_REPORT)) cs_have_nxt = 1'b0;
    else if (cs_pulse_s)                                     cs_have_nxt = 1'b1;
    else                                                     cs_have_nxt = cs_have_r;
  end

  // State, datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_HUNT;
      acc_r     <= 10'd0;
      dcnt_r    <= 2'd0;
      timer_r   <= 16'd0;
      cs_val_r  <= 8'd0;
      cs_have_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      match_r   <= 1'b0;
      fmt_err_r <= 1'b0;
      timeout_r <= 1'b0;
      rx_cs_r   <= 8'd0;
    end else begin
      state_r   <= state_nxt;
      acc_r     <= acc_nxt;
      dcnt_r    <= dcnt_nxt;
      timer_r   <= timer_nxt;
      cs_val_r  <= cs_val_s;
      cs_have_r <= cs_have_nxt;
      busy_r    <= (state_nxt == ST_WAIT_CS) || (state_nxt == ST_REPORT);
      done_r    <= (state_nxt == ST_REPORT);
      if (state_nxt == ST_REPORT) begin
        rx_cs_r   <= acc_nxt[7:0];
        fmt_err_r <= fmt_err_s;
        timeout_r <= to_s;
        match_r   <= !fmt_err_s && !to_s && (acc_nxt[7:0] == cs_val_s);
      end else begin
        rx_cs_r   <= rx_cs_r;
        fmt_err_r <= fmt_err_r;
        timeout_r <= timeout_r;
        match_r   <= match_r;
      end
    end
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign match_o   = match_r;
  assign fmt_err_o = fmt_err_r;
  assign timeout_o = timeout_r;
  assign rx_cs_o   = rx_cs_r;

`ifdef FIX_TRAILER_STATS_EN
  logic [15:0] good_cnt_r, bad_cnt_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count each reported message once, in the REPORT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt_r <= 16'd0;
      bad_cnt_r  <= 16'd0;
    end else if (done_r) begin
      if (match_r) good_cnt_r <= sat_inc(good_cnt_r);
      else         bad_cnt_r  <= sat_inc(bad_cnt_r);
    end else begin
      good_cnt_r <= good_cnt_r;
      bad_cnt_r  <= bad_cnt_r;
    end
  end

  assign good_cnt_o = good_cnt_r;
  assign bad_cnt_o  = bad_cnt_r;
`else
  assign good_cnt_o = 16'd0;
  assign bad_cnt_o  = 16'd0;
`endif

endmodule

// File: tb/tb_fix_trailer_check.sv
// Directed testbench for fix_trailer_check (TIMEOUT_CYC = 64, SOH = 8'h01).
module tb_fix_trailer_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_i = 8'd0;
  logic        valid_i = 1'b0;
  logic [7:0]  checksum_i = 8'd0;
  logic        checksum_valid_i = 1'b0;
  logic        busy_o, done_o, match_o, fmt_err_o, timeout_o;
  logic [7:0]  rx_cs_o;
  logic [15:0] good_cnt_o, bad_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int early_done;
  int exp_good = 0;
  int exp_bad = 0;
  logic [7:0] seq [8];

  fix_trailer_check #(.TIMEOUT_CYC(64), .SOH_CHAR(8'h01)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .checksum_i(checksum_i), .checksum_valid_i(checksum_valid_i),
    .busy_o(busy_o), .done_o(done_o), .match_o(match_o), .fmt_err_o(fmt_err_o),
    .timeout_o(timeout_o), .rx_cs_o(rx_cs_o), .good_cnt_o(good_cnt_o), .bad_cnt_o(bad_cnt_o)
  );

  always #5 clk = ~clk;

  // One clock: apply inputs, wait for the edge, then sample 1 time unit later
  task automatic drive(input logic v, input logic [7:0] d, input logic cv, input logic [7:0] c);
    valid_i = v; data_i = d; checksum_valid_i = cv; checksum_i = c;
    @(posedge clk); #1;
    valid_i = 1'b0; checksum_valid_i = 1'b0;
  endtask

  // Send seq[0..n-1]; optional checksum pulses on byte indices pa/pb (-1 = none)
  task automatic send_bytes(input int n, input int pa, input logic [7:0] ca,
                            input int pb, input logic [7:0] cb);
    early_done = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, seq[i], (i == pa) || (i == pb), (i == pb) ? cb : ca);
      if (done_o === 1'b1 && i < n - 1) early_done++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; drive(1'b0, 8'd0, 1'b0, 8'd0); drive(1'b0, 8'd0, 1'b0, 8'd0); rst = 1'b0;
    n_checks++;
    if ({busy_o, done_o, match_o, fmt_err_o, timeout_o, rx_cs_o, good_cnt_o, bad_cnt_o} !== 45'd0) begin
      n_errors++; $display("FAIL reset_outputs: got %b %b %b %b %b %h %h %h required all zero",
                           busy_o, done_o, match_o, fmt_err_o, timeout_o, rx_cs_o, good_cnt_o, bad_cnt_o);
    end
  endtask

  task automatic test_match;
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h31, 8'h32, 8'h38, 8'h01};
    send_bytes(8, 5, 8'h80, -1, 8'h00);
    n_checks++;
    if ({early_done == 0, done_o, match_o, fmt_err_o, timeout_o, rx_cs_o} !== {5'b11100, 8'h80}) begin
      n_errors++; $display("FAIL match_128: early=%0d done=%b match=%b fmt=%b to=%b rx=%h required 0 1 1 0 0 80",
                           early_done, done_o, match_o, fmt_err_o, timeout_o, rx_cs_o);
    end
    exp_good++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    n_checks++;
    if ({done_o, match_o, rx_cs_o} !== {2'b01, 8'h80}) begin
      n_errors++; $display("FAIL match_hold: done=%b match=%b rx=%h required 0 1 80", done_o, match_o, rx_cs_o);
    end
  endtask

  task automatic test_mismatch;
    send_bytes(8, 5, 8'h81, -1, 8'h00);
    n_checks++;
    if ({done_o, match_o, fmt_err_o, timeout_o, rx_cs_o} !== {4'b1000, 8'h80}) begin
      n_errors++; $display("FAIL mismatch_81: done=%b match=%b fmt=%b to=%b rx=%h required 1 0 0 0 80",
                           done_o, match_o, fmt_err_o, timeout_o, rx_cs_o);
    end
    exp_bad++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_fmt_nondigit;
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h31, 8'h41, 8'h00, 8'h00};
    send_bytes(6, 4, 8'h01, -1, 8'h00);
    n_checks++;
    if ({early_done == 0, done_o, match_o, fmt_err_o} !== 4'b1101) begin
      n_errors++; $display("FAIL fmt_nondigit: early=%0d done=%b match=%b fmt=%b required 0 1 0 1",
                           early_done, done_o, match_o, fmt_err_o);
    end
    exp_bad++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_overflow;
    // 300 mod 256 = 0x2C equals the checksum, but the value is out of range
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h33, 8'h30, 8'h30, 8'h01};
    send_bytes(8, 4, 8'h2C, -1, 8'h00);
    n_checks++;
    if ({done_o, match_o, fmt_err_o, rx_cs_o} !== {3'b101, 8'h2C}) begin
      n_errors++; $display("FAIL overflow_300: done=%b match=%b fmt=%b rx=%h required 1 0 1 2c",
                           done_o, match_o, fmt_err_o, rx_cs_o);
    end
    exp_bad++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_timeout;
    int wait_n;
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h31, 8'h32, 8'h01};
    send_bytes(8, -1, 8'h00, -1, 8'h00);
    n_checks++;
    if ({busy_o, done_o} !== 2'b10) begin
      n_errors++; $display("FAIL wait_cs_busy: busy=%b done=%b required 1 0", busy_o, done_o);
    end
    wait_n = -1;
    for (int i = 1; i <= 200; i++) begin
      drive(1'b0, 8'd0, 1'b0, 8'd0);
      if (done_o === 1'b1) begin wait_n = i; break; end
    end
    n_checks++;
    if (wait_n != 64) begin
      n_errors++; $display("FAIL timeout_latency: got %0d cycles required 64 (-1 = never)", wait_n);
    end
    n_checks++;
    if ({timeout_o, match_o, fmt_err_o, rx_cs_o} !== {3'b100, 8'h0C}) begin
      n_errors++; $display("FAIL timeout_flags: to=%b match=%b fmt=%b rx=%h required 1 0 0 0c",
                           timeout_o, match_o, fmt_err_o, rx_cs_o);
    end
    exp_bad++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_no_trigger;
    int seen;
    seq = '{8'h01, 8'h31, 8'h30, 8'h30, 8'h3D, 8'h35, 8'h01, 8'h00};
    send_bytes(7, 5, 8'h05, -1, 8'h00);
    seen = early_done + (done_o === 1'b1 ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 1'b0, 8'd0);
      if (done_o === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL no_trigger_100: got %0d done pulses required 0", seen);
    end
`ifdef FIX_TRAILER_STATS_EN
    n_checks++;
    if ({good_cnt_o, bad_cnt_o} !== {16'(exp_good), 16'(exp_bad)}) begin
      n_errors++; $display("FAIL stats_mid: good=%0d bad=%0d required %0d %0d", good_cnt_o, bad_cnt_o, exp_good, exp_bad);
    end
`endif
  endtask

  task automatic test_mid_reset;
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h31, 8'h00, 8'h00, 8'h00};
    send_bytes(5, -1, 8'h00, -1, 8'h00);
    rst = 1'b1; drive(1'b0, 8'd0, 1'b0, 8'd0); rst = 1'b0;
    exp_good = 0; exp_bad = 0;
    n_checks++;
    if ({busy_o, done_o, match_o, fmt_err_o, timeout_o, rx_cs_o, good_cnt_o, bad_cnt_o} !== 45'd0) begin
      n_errors++; $display("FAIL mid_reset_outputs: got %b %b %b %b %b %h %h %h required all zero",
                           busy_o, done_o, match_o, fmt_err_o, timeout_o, rx_cs_o, good_cnt_o, bad_cnt_o);
    end
    // Checksum pulse lands in the same cycle as the terminating SOH
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h32, 8'h30, 8'h30, 8'h01};
    send_bytes(8, 7, 8'hC8, -1, 8'h00);
    n_checks++;
    if ({early_done == 0, done_o, match_o, fmt_err_o, rx_cs_o} !== {4'b1110, 8'hC8}) begin
      n_errors++; $display("FAIL after_reset_200: early=%0d done=%b match=%b fmt=%b rx=%h required 0 1 1 0 c8",
                           early_done, done_o, match_o, fmt_err_o, rx_cs_o);
    end
    exp_good++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_latest_wins;
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h30, 8'h37, 8'h01};
    send_bytes(8, 4, 8'h11, 6, 8'h07);
    n_checks++;
    if ({done_o, match_o, rx_cs_o} !== {2'b11, 8'h07}) begin
      n_errors++; $display("FAIL latest_wins_007: done=%b match=%b rx=%h required 1 1 07", done_o, match_o, rx_cs_o);
    end
    exp_good++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back;
    int seen;
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h34, 8'h32, 8'h01};
    send_bytes(8, -1, 8'h00, -1, 8'h00);
    seen = (done_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 1'b0, 8'd0);
      if (done_o !== 1'b0 || busy_o !== 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL late_wait: got %0d bad cycles required 0 (busy=1, done=0)", seen);
    end
    drive(1'b0, 8'd0, 1'b1, 8'h2A);
    n_checks++;
    if ({done_o, match_o, rx_cs_o} !== {2'b11, 8'h2A}) begin
      n_errors++; $display("FAIL late_checksum_042: done=%b match=%b rx=%h required 1 1 2a", done_o, match_o, rx_cs_o);
    end
    exp_good++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    seq = '{8'h01, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h31, 8'h30, 8'h01};
    send_bytes(8, 7, 8'h0A, -1, 8'h00);
    n_checks++;
    if ({early_done == 0, done_o, match_o, rx_cs_o} !== {3'b111, 8'h0A}) begin
      n_errors++; $display("FAIL back_to_back_010: early=%0d done=%b match=%b rx=%h required 0 1 1 0a",
                           early_done, done_o, match_o, rx_cs_o);
    end
    exp_good++;
    drive(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic test_stats;
    n_checks++;
`ifdef FIX_TRAILER_STATS_EN
    if ({good_cnt_o, bad_cnt_o} !== {16'(exp_good), 16'(exp_bad)}) begin
      n_errors++; $display("FAIL stats_final: good=%0d bad=%0d required %0d %0d", good_cnt_o, bad_cnt_o, exp_good, exp_bad);
    end
`else
    if ({good_cnt_o, bad_cnt_o} !== 32'd0) begin
      n_errors++; $display("FAIL stats_tied_zero: good=%0d bad=%0d required 0 0", good_cnt_o, bad_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_match;
    test_mismatch;
    test_fmt_nondigit;
    test_overflow;
    test_timeout;
    test_no_trigger;
    test_mid_reset;
    test_latest_wins;
    test_back_to_back;
    test_stats;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
